regbank_wb_arbiter: RTL and testbench

- Controller for the register bank's single write port (C, Cdata, W).
- Arbitrates two writeback requesters (ALU, memory load) round-robin through one registered output stage.
- Keeps a 32-entry pending-write scoreboard so issue logic can detect read-after-write hazards on read ports A/B and write-after-write hazards on issue.

---
 rtl/regbank_wb_arbiter_if.sv | 39 +++
 rtl/regbank_wb_arbiter.sv | 95 +++++++++
 tb/tb_regbank_wb_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regbank_wb_arbiter_if.sv
// Bundle of writeback, issue and read-port signals between the pipeline and the
// register-bank write-port controller.
interface regbank_wb_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [ADDR_W-1:0] C;
    logic [DATA_W-1:0] Cdata;
    logic              W;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_dst;
    logic              issue_ready;
    logic [ADDR_W-1:0] A;
    logic [ADDR_W-1:0] B;
    logic              A_busy;
    logic              B_busy;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        output issue_valid, issue_dst, A, B,
        input  alu_ready, mem_ready, C, Cdata, W, issue_ready, A_busy, B_busy
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        input  issue_valid, issue_dst, A, B,
        output alu_ready, mem_ready, C, Cdata, W, issue_ready, A_busy, B_busy
    );
endinterface

// File: rtl/regbank_wb_arbiter.sv
// Round-robin ALU/load writeback arbiter driving the register bank write port,
// with a pending-write scoreboard for RAW/WAW hazard detection.
module regbank_wb_arbiter #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic             CLK,
    input  logic             RESETn,
    regbank_wb_arbiter_if.slave bus
);
    localparam int NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_t;

    grant_t            last_grant_reg;
    logic              grant_alu;
    logic              grant_mem;
    logic              grant_any;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_data;
    logic              issue_set;
    logic [NREG-1:0]   pending_reg;
    logic [NREG-1:0]   pending_next;
    logic              w_reg;
    logic [ADDR_W-1:0] c_reg;
    logic [DATA_W-1:0] cdata_reg;

    // ALU wins unless the load port is also asking and ALU had the previous grant.
    always_comb begin
        grant_alu  = RESETn && bus.alu_valid &&
                     (!bus.mem_valid || (last_grant_reg == GRANT_MEM));
        grant_mem  = RESETn && bus.mem_valid && !grant_alu;
        grant_any  = grant_alu || grant_mem;
        grant_addr = grant_alu ? bus.alu_addr : bus.mem_addr;
        grant_data = grant_alu ? bus.alu_data : bus.mem_data;
    end

    assign bus.alu_ready   = grant_alu;
    assign bus.mem_ready   = grant_mem;
    assign bus.issue_ready = !pending_reg[bus.issue_dst];
    assign issue_set       = bus.issue_valid && bus.issue_ready &&
                             (bus.issue_dst != ZERO_ADDR);

    // Per-register reservation: a new issue overrides a retiring writeback.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
            localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
            if (gi == ZERO_REG) begin : g_zero
                assign pending_next[gi] = 1'b0;
            end else begin : g_reg
                logic set_bit;
                logic clr_bit;
                assign set_bit = issue_set && (bus.issue_dst == IDX);
                assign clr_bit = grant_any && (grant_addr == IDX);
                assign pending_next[gi] = set_bit | (pending_reg[gi] & ~clr_bit);
            end
        end
    endgenerate

    // The W term flags the cycle where the bank write has not yet landed.
    assign bus.A_busy = pending_reg[bus.A] |
                        (w_reg && (c_reg == bus.A) && (bus.A != ZERO_ADDR));
    assign bus.B_busy = pending_reg[bus.B] |
                        (w_reg && (c_reg == bus.B) && (bus.B != ZERO_ADDR));

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            w_reg          <= 1'b0;
            c_reg          <= '0;
            cdata_reg      <= '0;
            pending_reg    <= '0;
            last_grant_reg <= GRANT_MEM;
        end else begin
            pending_reg <= pending_next;
            w_reg       <= grant_any && (grant_addr != ZERO_ADDR);
            if (grant_any) begin
                last_grant_reg <= grant_alu ? GRANT_ALU : GRANT_MEM;
                // A grant to the zero register burns its slot but touches nothing.
                if (grant_addr != ZERO_ADDR) begin
                    c_reg     <= grant_addr;
                    cdata_reg <= grant_data;
                end
            end
        end
    end

    assign bus.W     = w_reg;
    assign bus.C     = c_reg;
    assign bus.Cdata = cdata_reg;
endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Directed and randomized checks of regbank_wb_arbiter against a reference model
// built from round-robin and scoreboard rules.
module tb_regbank_wb_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    regbank_wb_arbiter_if #(.DATA_W(64), .ADDR_W(5)) bus ();

    regbank_wb_arbiter #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(31)) dut (
        .CLK    (clk),
        .RESETn (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit [31:0]   m_pend;
    bit          m_last_alu;
    logic        m_W;
    logic [4:0]  m_C;
    logic [63:0] m_Cdata;
    bit          m_gr_alu;
    bit          m_gr_mem;
    logic [4:0]  c_seq [4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int winner();
        if (rst_n !== 1'b1) return 0;
        if (bus.alu_valid && bus.mem_valid) return m_last_alu ? 2 : 1;
        if (bus.alu_valid) return 1;
        if (bus.mem_valid) return 2;
        return 0;
    endfunction

    function automatic bit exp_busy(input logic [4:0] r);
        return m_pend[r] || (m_W && (m_C == r) && (r != 5'd31));
    endfunction

    task automatic model_reset();
        m_pend = '0; m_last_alu = 1'b0; m_W = 1'b0; m_C = '0; m_Cdata = '0;
        m_gr_alu = 1'b0; m_gr_mem = 1'b0;
    endtask

    task automatic clear_inputs();
        bus.alu_valid = 0; bus.alu_addr = '0; bus.alu_data = '0;
        bus.mem_valid = 0; bus.mem_addr = '0; bus.mem_data = '0;
        bus.issue_valid = 0; bus.issue_dst = '0; bus.A = '0; bus.B = '0;
    endtask

    // One clock: check combinational outputs, advance the model, check registers.
    task automatic step();
        int          w;
        logic [4:0]  ga;
        logic [63:0] gd;
        bit          set_ok;
        logic [4:0]  sdst;
        #1;
        w = winner();
        check("alu_ready", 64'(bus.alu_ready), 64'(w == 1));
        check("mem_ready", 64'(bus.mem_ready), 64'(w == 2));
        check("issue_ready", 64'(bus.issue_ready), 64'(!m_pend[bus.issue_dst]));
        check("A_busy", 64'(bus.A_busy), 64'(exp_busy(bus.A)));
        check("B_busy", 64'(bus.B_busy), 64'(exp_busy(bus.B)));
        set_ok = bus.issue_valid && !m_pend[bus.issue_dst] && (bus.issue_dst != 5'd31);
        sdst   = bus.issue_dst;
        ga     = (w == 1) ? bus.alu_addr : bus.mem_addr;
        gd     = (w == 1) ? bus.alu_data : bus.mem_data;
        @(posedge clk);
        m_gr_alu = (w == 1);
        m_gr_mem = (w == 2);
        m_W = 1'b0;
        if (w != 0) begin
            m_last_alu = (w == 1);
            m_pend[ga] = 1'b0;
            if (ga != 5'd31) begin
                m_W = 1'b1; m_C = ga; m_Cdata = gd;
            end
        end
        if (set_ok) m_pend[sdst] = 1'b1;
        #1;
        check("W", 64'(bus.W), 64'(m_W));
        check("C", 64'(bus.C), 64'(m_C));
        check("Cdata", bus.Cdata, m_Cdata);
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_W", 64'(bus.W), 64'd0);
        check("rst_C", 64'(bus.C), 64'd0);
        check("rst_Cdata", bus.Cdata, 64'd0);
        bus.alu_valid = 1; bus.mem_valid = 1; bus.A = 5'd4; bus.B = 5'd9; bus.issue_dst = 5'd4;
        #1;
        check("rst_alu_ready", 64'(bus.alu_ready), 64'd0);
        check("rst_mem_ready", 64'(bus.mem_ready), 64'd0);
        check("rst_A_busy", 64'(bus.A_busy), 64'd0);
        check("rst_B_busy", 64'(bus.B_busy), 64'd0);
        check("rst_issue_ready", 64'(bus.issue_ready), 64'd1);
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [4:0] rand_addr();
        if ($urandom_range(9) == 0) return 5'd31;
        return 5'($urandom_range(7));
    endfunction

    initial begin
        clear_inputs();
        model_reset();

        // Reset then idle
        apply_reset();
        repeat (10) step();
        check("idle_W", 64'(bus.W), 64'd0);

        // Single ALU write
        bus.alu_valid = 1; bus.alu_addr = 5'd3; bus.alu_data = 64'hDEAD;
        #1;
        check("single_ready", 64'(bus.alu_ready), 64'd1);
        step();
        check("single_W", 64'(bus.W), 64'd1);
        check("single_C", 64'(bus.C), 64'd3);
        check("single_Cdata", bus.Cdata, 64'hDEAD);
        bus.alu_valid = 0;
        step();
        check("single_W_off", 64'(bus.W), 64'd0);

        // Conflict fairness from fresh reset
        apply_reset();
        bus.alu_valid = 1; bus.alu_addr = 5'd1; bus.alu_data = 64'h11;
        bus.mem_valid = 1; bus.mem_addr = 5'd2; bus.mem_data = 64'h22;
        for (int i = 0; i < 4; i++) begin
            step();
            c_seq[i] = bus.C;
            check("fair_W", 64'(bus.W), 64'd1);
        end
        check("fair_C0", 64'(c_seq[0]), 64'd1);
        check("fair_C1", 64'(c_seq[1]), 64'd2);
        check("fair_C2", 64'(c_seq[2]), 64'd1);
        check("fair_C3", 64'(c_seq[3]), 64'd2);
        clear_inputs();
        step();

        // Scoreboard RAW on register 5
        bus.issue_valid = 1; bus.issue_dst = 5'd5;
        step();
        bus.issue_valid = 0; bus.A = 5'd5;
        #1;
        check("raw_A_busy", 64'(bus.A_busy), 64'd1);
        check("raw_issue_ready", 64'(bus.issue_ready), 64'd0);
        bus.mem_valid = 1; bus.mem_addr = 5'd5; bus.mem_data = 64'h5555;
        step();
        bus.mem_valid = 0;
        check("raw_A_busy_wterm", 64'(bus.A_busy), 64'd1);
        step();
        check("raw_A_busy_clear", 64'(bus.A_busy), 64'd0);

        // Simultaneous set and clear on register 7
        bus.alu_valid = 1; bus.alu_addr = 5'd7; bus.alu_data = 64'h7777;
        bus.issue_valid = 1; bus.issue_dst = 5'd7;
        step();
        clear_inputs();
        bus.B = 5'd7;
        step();
        check("setclr_B_busy", 64'(bus.B_busy), 64'd1);

        // Zero register: granted, no write, no reservation, last grant moves
        bus.alu_valid = 1; bus.alu_addr = 5'd31; bus.alu_data = 64'hFFFF;
        bus.issue_valid = 1; bus.issue_dst = 5'd31;
        step();
        check("zero_W", 64'(bus.W), 64'd0);
        bus.alu_valid = 0; bus.issue_valid = 0;
        #1;
        check("zero_issue_ready", 64'(bus.issue_ready), 64'd1);
        bus.alu_valid = 1; bus.alu_addr = 5'd2; bus.mem_valid = 1; bus.mem_addr = 5'd6;
        #1;
        check("zero_rr_mem_ready", 64'(bus.mem_ready), 64'd1);
        step();
        clear_inputs();
        step();

        // Reset asserted while a write is in flight
        bus.alu_valid = 1; bus.alu_addr = 5'd9; bus.alu_data = 64'h9999;
        bus.issue_valid = 1; bus.issue_dst = 5'd12;
        step();
        check("midrst_W_before", 64'(bus.W), 64'd1);
        clear_inputs();
        bus.A = 5'd12;
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_W", 64'(bus.W), 64'd0);
        check("midrst_A_busy", 64'(bus.A_busy), 64'd0);
        check("midrst_C", 64'(bus.C), 64'd0);
        apply_reset();
        repeat (3) step();

        // Randomized traffic against the model
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!bus.alu_valid || m_gr_alu) begin
                bus.alu_valid = 1'($urandom_range(1));
                bus.alu_addr  = rand_addr();
                bus.alu_data  = {$urandom, $urandom};
            end else if ($urandom_range(7) == 0) begin
                bus.alu_valid = 1'b0;
            end
            if (!bus.mem_valid || m_gr_mem) begin
                bus.mem_valid = 1'($urandom_range(1));
                bus.mem_addr  = rand_addr();
                bus.mem_data  = {$urandom, $urandom};
            end else if ($urandom_range(7) == 0) begin
                bus.mem_valid = 1'b0;
            end
            bus.issue_valid = ($urandom_range(2) == 0);
            bus.issue_dst   = rand_addr();
            bus.A           = rand_addr();
            bus.B           = rand_addr();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
